input_event_arbiter: RTL and testbench
======================================

INPUT_EVENT_ARBITER -- requirements
Module: input_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of conditioned input channels (2..8).
REQ-002 SHALL have parameter DEPTH, default 8, meaning event FIFO depth (power of two, >=2).
REQ-003 SHALL have parameter TS_W, default 16, meaning timestamp width (used only when the timestamp feature is enabled).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rising  input  NCH  one-cycle positiveedge pulses, one bit per conditioner channel.
REQ-007 SHALL have port falling  input  NCH  one-cycle negativeedge pulses, one bit per conditioner channel.
REQ-008 SHALL have port out_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head; pop when out_valid && out_ready.
REQ-010 SHALL have port out_chan  output  clog2(NCH)  channel index of head event.
REQ-011 SHALL have port out_edge  output  1  head edge type: 1 = rising, 0 = falling.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-015 SHALL keep one pending slot per channel (valid bit + edge type); a pulse on rising[i] or falling[i] at clock edge k sets slot i after edge k.
REQ-016 SHALL, if rising[i] and falling[i] are both high in the same cycle, drop both and set overflow.
REQ-017 SHALL, if a pulse arrives for a channel whose slot is still valid and not granted that cycle, drop the new pulse, keep the old one, and set overflow.
REQ-018 SHALL, if a slot is granted in the same cycle a new pulse arrives on that channel, load the new pulse into the slot (no drop).
REQ-019 SHALL grant at most one pending slot per cycle, round-robin: search starts at last granted index + 1 mod NCH; the pointer after reset is NCH-1, so channel 0 has first priority.
REQ-020 SHALL grant only when count < DEPTH or a pop occurs in the same cycle; a grant writes {chan, edge} to the FIFO tail and clears the slot.
REQ-021 SHALL give latency of exactly 2 cycles from pulse to out_valid when the FIFO is empty and no other slot is pending (pulse at edge k, slot at k, push at k+1, out_valid after k+1).
REQ-022 SHALL hold out_chan/out_edge stable while out_valid && !out_ready.
REQ-023 SHALL, with simultaneous push and pop at full, accept both and leave count at DEPTH; with push and pop while empty, set out_valid next cycle (no bypass).
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL clear overflow on overflow_clr unless a drop occurs in the same cycle (set wins).

Reset
REQ-026 SHALL on reset: out_valid=0, count=0, overflow=0, out_chan=0, out_edge=0, all slots invalid, pointers 0, round-robin pointer NCH-1.
REQ-027 SHALL discard in-flight pulses and FIFO contents when reset is asserted mid-operation; pulses during reset are ignored.

Configuration
REQ-028 SHALL, with INPUT_EVENT_TIMESTAMP_EN defined, run a free-running TS_W-bit cycle counter (reset 0, wraps), capture it into the slot when the pulse is taken, store it in the FIFO entry, and present it on output out_timestamp [TS_W] with the head.
REQ-029 SHALL, without INPUT_EVENT_TIMESTAMP_EN, omit the counter, the timestamp storage, and the out_timestamp port; all other behaviour is identical.

Structure
REQ-030 SHALL take edge encodings (EDGE_RISE=1, EDGE_FALL=0) and FIFO entry field offsets from shared package input_event_pkg.
REQ-031 SHALL place the FIFO in sub-module event_fifo (parameterized width and depth, valid/ready, count); the arbiter and pending slots stay in the top module.

Verification
REQ-032 SHALL test a single pulse: rising[2] for 1 cycle, empty FIFO -> out_valid 2 cycles later, out_chan=2, out_edge=1, count=1.
REQ-033 SHALL test simultaneous pulses: rising[0], rising[1], falling[3] in one cycle, out_ready=1 -> events popped in order ch0, ch1, ch3, one per cycle.
REQ-034 SHALL test fairness: ch0 and ch1 re-pulsed every time their slot clears, out_ready=1 -> grants alternate 0,1,0,1 with no starvation.
REQ-035 SHALL test the full FIFO: out_ready=0, 9 pulses on distinct cycles, ch0 alternating edges -> count=8, the 9th is held pending; a 10th pulse on ch0 sets overflow; overflow_clr then clears it.
REQ-036 SHALL test conflicting edges: rising[1] and falling[1] in the same cycle -> no event queued, overflow=1.
REQ-037 SHALL test reset mid-stream: reset for 1 cycle with count=5 -> next cycle count=0, out_valid=0, overflow=0; with INPUT_EVENT_TIMESTAMP_EN, pulses 3 cycles apart carry out_timestamp values differing by 3.

Source files
------------

// File: rtl/input_event_pkg.sv
// input_event_pkg: shared edge encodings and FIFO entry field layout for
// the input event arbiter. Entry layout, LSB first: edge, channel, timestamp.
package input_event_pkg;

   localparam logic EDGE_RISE = 1'b1;
   localparam logic EDGE_FALL = 1'b0;

   localparam int unsigned EDGE_OFF = 0;
   localparam int unsigned CHAN_OFF = 1;

   // Timestamp field sits directly above the channel field.
   function automatic int unsigned ts_off(input int unsigned ch_w);
      return CHAN_OFF + ch_w;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: flop-based FIFO with valid/ready on both sides and occupancy.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready_c   push handshake (ready is combinational: room or pop)
//   in_data               entry to write at the tail
//   out_valid/out_ready   pop handshake; out_valid is registered
//   out_data              head entry
//   count                 occupancy 0..DEPTH
module event_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready_c,
   input  logic [W-1:0]             in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count_next;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   always_comb begin
      pop        = out_valid && out_ready;
      in_ready_c = (count < CNT_W'(DEPTH)) || pop;
      push       = in_valid && in_ready_c;
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   assign out_data = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem       <= '{default: '0};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count     <= count_next;
         out_valid <= (count_next != '0);
      end
   end

endmodule

// File: rtl/input_event_arbiter.sv
// input_event_arbiter: collects one-cycle edge pulses from NCH conditioner
// channels into per-channel pending slots, round-robin grants one slot per
// cycle into an event FIFO, and flags dropped events with a sticky overflow.
// Optional feature: define INPUT_EVENT_TIMESTAMP_EN to add a free-running
// TS_W-bit cycle counter whose value is captured per event and presented on
// out_timestamp.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rising, falling       per-channel edge pulses
//   out_valid/out_ready   head handshake
//   out_chan, out_edge    head event channel and edge (1 rise, 0 fall)
//   count                 FIFO occupancy
//   overflow/overflow_clr sticky drop flag and its clear
//   out_timestamp         head capture time (timestamp build only)
module input_event_arbiter
   import input_event_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TS_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NCH-1:0]           rising,
   input  logic [NCH-1:0]           falling,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(NCH)-1:0]   out_chan,
   output logic                     out_edge,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     overflow_clr
`ifdef INPUT_EVENT_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]          out_timestamp
`endif
);

   localparam int unsigned CH_W    = $clog2(NCH);
`ifdef INPUT_EVENT_TIMESTAMP_EN
   localparam bit          TS_EN   = 1'b1;
`else
   localparam bit          TS_EN   = 1'b0;
`endif
   localparam int unsigned TS_BITS = TS_EN ? TS_W : 0;
   localparam int unsigned TS_OFF  = ts_off(CH_W);
   localparam int unsigned ENTRY_W = TS_OFF + TS_BITS;

   logic [NCH-1:0]     slot_valid;
   logic [NCH-1:0]     slot_edge;
   logic [NCH-1:0]     take;
   logic [NCH-1:0]     drop;
   logic [NCH-1:0]     gnt_vec;
   logic [CH_W-1:0]    rr_ptr;
   logic [CH_W-1:0]    grant_idx;
   logic [CH_W-1:0]    cand;
   logic               found;
   logic               grant;
   logic               fifo_ready_c;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] head_data;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned off = 1; off <= NCH; off++) begin
         cand = CH_W'((32'(rr_ptr) + off) % NCH);
         if (!found && slot_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      grant   = found && fifo_ready_c;
      gnt_vec = '0;
      if (grant) begin
         gnt_vec[grant_idx] = 1'b1;
      end
   end

   // A slot being granted this cycle is free to take a new pulse.
   always_comb begin
      take = '0;
      drop = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rising[i] && falling[i]) begin
            drop[i] = 1'b1;
         end else if (rising[i] || falling[i]) begin
            if (!slot_valid[i] || gnt_vec[i]) begin
               take[i] = 1'b1;
            end else begin
               drop[i] = 1'b1;
            end
         end
      end
   end

   // Pending slots, round-robin pointer and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid <= '0;
         slot_edge  <= '0;
         rr_ptr     <= CH_W'(NCH - 1);
         overflow   <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (take[i]) begin
               slot_valid[i] <= 1'b1;
               slot_edge[i]  <= rising[i] ? EDGE_RISE : EDGE_FALL;
            end else if (gnt_vec[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
         if (grant) begin
            rr_ptr <= grant_idx;
         end
         if (|drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef INPUT_EVENT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] slot_ts [NCH];

   // Free-running capture clock; each slot latches it when a pulse is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt  <= '0;
         slot_ts <= '{default: '0};
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         for (int i = 0; i < NCH; i++) begin
            if (take[i]) begin
               slot_ts[i] <= ts_cnt;
            end
         end
      end
   end

   assign push_data     = {slot_ts[grant_idx], grant_idx, slot_edge[grant_idx]};
   assign out_timestamp = head_data[TS_OFF +: TS_W];
`else
   assign push_data     = {grant_idx, slot_edge[grant_idx]};
`endif

   event_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (grant),
      .in_ready_c (fifo_ready_c),
      .in_data    (push_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (head_data),
      .count      (count)
   );

   assign out_chan = head_data[CHAN_OFF +: CH_W];
   assign out_edge = head_data[EDGE_OFF];

endmodule

// File: tb/tb_input_event_arbiter.sv
// tb_input_event_arbiter: randomized and directed stimulus against a
// queue-based reference model; a negedge monitor compares the DUT head,
// occupancy and overflow flag with the model's expected-event queue.
module tb_input_event_arbiter;

   localparam int NCH   = 4;
   localparam int DEPTH = 8;
   localparam int TS_W  = 16;

   typedef struct {
      int              ch;
      bit              e;
      logic [TS_W-1:0] ts;
   } ev_t;

   logic                     clk;
   logic                     reset;
   logic [NCH-1:0]           rising;
   logic [NCH-1:0]           falling;
   logic                     out_valid;
   logic                     out_ready;
   logic [$clog2(NCH)-1:0]   out_chan;
   logic                     out_edge;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     overflow_clr;
`ifdef INPUT_EVENT_TIMESTAMP_EN
   logic [TS_W-1:0]          out_timestamp;
`endif

   input_event_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .rising       (rising),
      .falling      (falling),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_chan     (out_chan),
      .out_edge     (out_edge),
      .count        (count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
`ifdef INPUT_EVENT_TIMESTAMP_EN
      ,
      .out_timestamp(out_timestamp)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // Reference model state
   ev_t             exp_q[$];
   bit              pend_v [NCH];
   bit              pend_e [NCH];
   logic [TS_W-1:0] pend_t [NCH];
   int              rr     = NCH - 1;
   int              m_cnt  = 0;
   bit              m_ovf  = 1'b0;
   logic [TS_W-1:0] m_ts   = '0;

   int              pop_log[$];
   logic [TS_W-1:0] pop_ts[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the behavioural rules, applied to the inputs seen at the edge.
   task automatic model_step();
      bit  pop;
      bit  room;
      bit  drp;
      int  g;
      ev_t ev;
      if (reset) begin
         for (int i = 0; i < NCH; i++) pend_v[i] = 1'b0;
         exp_q.delete();
         rr    = NCH - 1;
         m_cnt = 0;
         m_ovf = 1'b0;
         m_ts  = '0;
         return;
      end
      pop  = (m_cnt > 0) && out_ready;
      room = (m_cnt < DEPTH) || pop;
      g    = -1;
      if (room) begin
         for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (rr + k) % NCH;
            if (g < 0 && pend_v[c]) g = c;
         end
      end
      if (pop) m_cnt--;
      if (g >= 0) begin
         ev.ch = g;
         ev.e  = pend_e[g];
         ev.ts = pend_t[g];
         exp_q.push_back(ev);
         m_cnt++;
         pend_v[g] = 1'b0;
         rr = g;
      end
      drp = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (rising[i] && falling[i]) begin
            drp = 1'b1;
         end else if (rising[i] || falling[i]) begin
            if (pend_v[i]) begin
               drp = 1'b1;
            end else begin
               pend_v[i] = 1'b1;
               pend_e[i] = rising[i];
               pend_t[i] = m_ts;
            end
         end
      end
      if (drp) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_ts = m_ts + 1'b1;
   endtask

   task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] f,
                       input logic rdy, input logic clr, input logic rst);
      rising       = r;
      falling      = f;
      out_ready    = rdy;
      overflow_clr = clr;
      reset        = rst;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step('0, '0, rdy, 1'b0, 1'b0);
   endtask

   // Monitor: compares every cycle away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("count", 64'(count), 64'(m_cnt));
         chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL head_unexpected: chan %0d with no expected event", out_chan);
            end else begin
               chk("head_chan", 64'(out_chan), 64'(exp_q[0].ch));
               chk("head_edge", 64'(out_edge), 64'(exp_q[0].e));
`ifdef INPUT_EVENT_TIMESTAMP_EN
               chk("head_ts", 64'(out_timestamp), 64'(exp_q[0].ts));
`endif
               if (out_ready) begin
                  pop_log.push_back(exp_q[0].ch);
                  pop_ts.push_back(exp_q[0].ts);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [NCH-1:0] r;
      logic [NCH-1:0] f;
      bit             alt_ok;

      rising = '0; falling = '0; out_ready = 1'b0; overflow_clr = 1'b0; reset = 1'b1;

      // Reset state
      step('0, '0, 1'b0, 1'b0, 1'b1);
      step('0, '0, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_out_chan", 64'(out_chan), 64'(0));
      chk("rst_out_edge", 64'(out_edge), 64'(0));

      // Single pulse: visible two edges after the pulse
      step(4'b0100, '0, 1'b0, 1'b0, 1'b0);
      chk("single_lat1_valid", 64'(out_valid), 64'(0));
      step('0, '0, 1'b0, 1'b0, 1'b0);
      chk("single_valid", 64'(out_valid), 64'(1));
      chk("single_chan", 64'(out_chan), 64'(2));
      chk("single_edge", 64'(out_edge), 64'(1));
      chk("single_count", 64'(count), 64'(1));
      idle(3, 1'b1);

      // Simultaneous pulses drain in channel order after reset
      step('0, '0, 1'b0, 1'b0, 1'b1);
      pop_log.delete();
      step(4'b0011, 4'b1000, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b1);
      chk("simul_n", 64'(pop_log.size()), 64'(3));
      if (pop_log.size() == 3) begin
         chk("simul_0", 64'(pop_log[0]), 64'(0));
         chk("simul_1", 64'(pop_log[1]), 64'(1));
         chk("simul_2", 64'(pop_log[2]), 64'(3));
      end

      // Fairness: ch0/ch1 re-pulsed whenever their slot is clear
      pop_log.delete();
      for (int c = 0; c < 16; c++) begin
         r = '0;
         r[0] = !pend_v[0];
         r[1] = !pend_v[1];
         step(r, '0, 1'b1, 1'b0, 1'b0);
      end
      idle(6, 1'b1);
      chk("fair_enough", 64'(pop_log.size() >= 8), 64'(1));
      alt_ok = (pop_log.size() > 0) && (pop_log[0] == 0);
      for (int k = 1; k < pop_log.size(); k++) begin
         if (pop_log[k] == pop_log[k-1]) alt_ok = 1'b0;
      end
      chk("fair_alternate", 64'(alt_ok), 64'(1));

      // Full FIFO with ch0 alternating edges, then overflow set and cleared
      for (int j = 0; j < 9; j++) begin
         step((j % 2 == 0) ? 4'b0001 : 4'b0000, (j % 2 == 0) ? 4'b0000 : 4'b0001,
              1'b0, 1'b0, 1'b0);
      end
      idle(1, 1'b0);
      chk("full_count", 64'(count), 64'(8));
      chk("full_no_ovf", 64'(overflow), 64'(0));
      step(4'b0001, '0, 1'b0, 1'b0, 1'b0);
      chk("full_ovf_set", 64'(overflow), 64'(1));
      step('0, '0, 1'b0, 1'b1, 1'b0);
      chk("full_ovf_clr", 64'(overflow), 64'(0));
      idle(12, 1'b1);
      chk("full_drained", 64'(count), 64'(0));

      // Conflicting edges on one channel
      step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1);
      chk("conflict_count", 64'(count), 64'(0));
      chk("conflict_ovf", 64'(overflow), 64'(1));
      step('0, '0, 1'b1, 1'b1, 1'b0);

      // Reset mid-stream with count=5; pulses during reset are ignored
      step(4'b1001, 4'b1000, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) step(4'b0001, '0, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("mid_count5", 64'(count), 64'(5));
      chk("mid_ovf", 64'(overflow), 64'(1));
      step('1, '0, 1'b0, 1'b0, 1'b1);
      chk("mid_rst_count", 64'(count), 64'(0));
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_ovf", 64'(overflow), 64'(0));
      idle(1, 1'b0);
      chk("mid_rst_ignored", 64'(count), 64'(0));

`ifdef INPUT_EVENT_TIMESTAMP_EN
      pop_ts.delete();
      step(4'b0001, '0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(4'b0010, '0, 1'b0, 1'b0, 1'b0);
      idle(6, 1'b1);
      chk("ts_n", 64'(pop_ts.size()), 64'(2));
      if (pop_ts.size() == 2) chk("ts_delta", 64'(pop_ts[1] - pop_ts[0]), 64'(3));
`endif

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         r = NCH'($urandom & $urandom);
         f = NCH'($urandom & $urandom);
         step(r, f, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 199) == 0));
      end
      idle(20, 1'b1);
      chk("final_empty", 64'(exp_q.size()), 64'(0));
      chk("final_count", 64'(count), 64'(0));

      @(negedge clk);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
